// File: rtl/fp_norm_round.sv
// fp_norm_round: post-add normalise / round-to-nearest-even / pack stage.
// Takes the raw 28-bit adder sum plus the larger operand's biased exponent and
// the result sign. Normalises one left shift per cycle, rounds, and packs an
// IEEE-754 single. valid/ready handshake on input and output.
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   in_valid / in_ready   input handshake; in_ready high only while idle
//   sum_i                 [SUM_W-1]=carry, [SUM_W-2]=hidden, frac, then G,R,S
//   exp_i, sign_i         biased exponent of larger operand, result sign
//   out_valid / out_ready output handshake
//   result_o              {sign, exp, frac}
//   overflow_o            result saturated to infinity
//   zero_o                sum was exactly zero
module fp_norm_round #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [MAN_W+4:0]       sum_i,
  input  logic [EXP_W-1:0]       exp_i,
  input  logic                   sign_i,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result_o,
  output logic                   overflow_o,
  output logic                   zero_o
);

  localparam int unsigned SUM_W = MAN_W + 5;
  localparam int unsigned XE_W  = EXP_W + 1;
  localparam int unsigned RND_W = MAN_W + 2;
  localparam int unsigned RES_W = 1 + EXP_W + MAN_W;
  localparam logic [XE_W-1:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  state_t            state;
  logic [SUM_W-1:0]  mant_q;
  logic [XE_W-1:0]   exp_q;
  logic              sign_q;

  logic              inc;
  logic [RND_W-1:0]  m_rnd;
  logic [XE_W-1:0]   e_rnd;
  logic [MAN_W-1:0]  frac_rnd;
  logic              ovf;
  logic              normalized;

  // Carry bit is always clear after capture; included so the hidden-bit test
  // covers the whole upper part of the register.
  assign normalized = mant_q[SUM_W-2] | mant_q[SUM_W-1];

  // Round-to-nearest-even on the normalised mantissa. A rounded value with
  // no hidden bit is a denormal (exp field 0); rounding into the hidden bit
  // gives exp field 1, which is exactly exp_q in the denormal case.
  always_comb begin
    inc      = mant_q[2] & (mant_q[1] | mant_q[0] | mant_q[3]);
    m_rnd    = {1'b0, mant_q[SUM_W-2:3]} + RND_W'(inc);
    e_rnd    = '0;
    frac_rnd = m_rnd[MAN_W-1:0];
    if (m_rnd[MAN_W+1]) begin
      e_rnd    = exp_q + XE_W'(1);
      frac_rnd = '0;
    end else if (m_rnd[MAN_W]) begin
      e_rnd = exp_q;
    end
    ovf = (e_rnd >= EXP_MAX);
  end

  // Control FSM and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      result_o   <= '0;
      overflow_o <= 1'b0;
      zero_o     <= 1'b0;
      mant_q     <= '0;
      exp_q      <= '0;
      sign_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready   <= 1'b0;
            overflow_o <= 1'b0;
            zero_o     <= 1'b0;
            sign_q     <= sign_i;
            if (sum_i == '0) begin
              zero_o   <= 1'b1;
              result_o <= {sign_i, (RES_W-1)'(0)};
              state    <= DONE;
            end else if (sum_i[SUM_W-1]) begin
              // Carry out: shift right once, folding the lost bit into sticky.
              mant_q <= {1'b0, sum_i[SUM_W-1:2], sum_i[1] | sum_i[0]};
              exp_q  <= {1'b0, exp_i} + XE_W'(1);
              state  <= NORM;
            end else begin
              mant_q <= sum_i;
              exp_q  <= {1'b0, exp_i};
              state  <= NORM;
            end
          end
        end
        NORM: begin
          if (normalized || exp_q <= XE_W'(1)) begin
            state <= ROUND;
          end else begin
            mant_q <= {mant_q[SUM_W-2:0], 1'b0};
            exp_q  <= exp_q - XE_W'(1);
          end
        end
        ROUND: begin
          overflow_o <= ovf;
          if (ovf) begin
            result_o <= {sign_q, {EXP_W{1'b1}}, MAN_W'(0)};
          end else begin
            result_o <= {sign_q, e_rnd[EXP_W-1:0], frac_rnd};
          end
          state <= DONE;
        end
        DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_norm_round.sv
// Randomised bench for fp_norm_round with a value-level reference model.
module tb_fp_norm_round;

  logic        clk, rst_n, in_valid, in_ready, sign_i;
  logic [27:0] sum_i;
  logic [7:0]  exp_i;
  logic        out_valid, out_ready, overflow_o, zero_o;
  logic [31:0] result_o;

  fp_norm_round #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .sum_i(sum_i), .exp_i(exp_i), .sign_i(sign_i),
    .out_valid(out_valid), .out_ready(out_ready),
    .result_o(result_o), .overflow_o(overflow_o), .zero_o(zero_o)
  );

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    logic        zero;
    int          lat;
    time         acc;
  } exp_t;

  exp_t   arr [0:1023];
  int     n_sent = 0, n_done = 0, n_vec = 0;
  int     n_cmp = 0, n_err = 0;
  logic   in_reset = 1'b1;
  logic   hold = 1'b0;
  logic   prev_ov = 1'b0;
  logic   pinned = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: value arithmetic on the sum, not a cycle model.
  function automatic exp_t model(input logic [27:0] s, input logic [7:0] e, input logic sg);
    exp_t r;
    longint m, q, rem;
    int ex, k, msb, ef;
    r.acc = 0;
    r.ovf = 1'b0;
    r.zero = (s == 0);
    if (s == 0) begin
      r.res = {sg, 31'h0};
      r.lat = 1;
      return r;
    end
    m = longint'(s);
    ex = int'(e);
    k = 0;
    if (s[27]) begin
      m = (m >> 1) | (m & 1);
      ex = ex + 1;
    end else begin
      msb = 0;
      for (int i = 0; i < 28; i++) if (s[i]) msb = i;
      k = 26 - msb;
      if (k > ex - 1) k = ex - 1;
      m = m << k;
      ex = ex - k;
    end
    q = m >> 3;
    rem = m & 7;
    if (rem > 4 || (rem == 4 && (q & 1) == 1)) q = q + 1;
    if (q >= (longint'(1) << 24)) begin
      q = q >> 1;
      ex = ex + 1;
    end
    ef = (q >= (longint'(1) << 23)) ? ex : 0;
    if (ef >= 255) begin
      r.res = {sg, 8'hFF, 23'h0};
      r.ovf = 1'b1;
    end else begin
      r.res = {sg, 8'(ef), 23'(q & 64'h7FFFFF)};
    end
    r.lat = 3 + k;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", nm, got, want, $time);
    end
  endtask

  task automatic pin(input logic [27:0] s, input logic [7:0] e, input logic sg,
                     input logic [31:0] res, input logic ovf, input logic zero, input int lat);
    exp_t r;
    r = model(s, e, sg);
    chk("model_res", r.res, res);
    chk("model_ovf", 32'(r.ovf), 32'(ovf));
    chk("model_zero", 32'(r.zero), 32'(zero));
    chk("model_lat", 32'(r.lat), 32'(lat));
  endtask

  // Single compare process: every negedge.
  always @(negedge clk) begin
    exp_t e;
    if (!pinned) begin
      pinned = 1'b1;
      pin(28'h4000000, 8'd127, 1'b0, 32'h3F800000, 1'b0, 1'b0, 3);
      pin(28'h8000000, 8'd127, 1'b0, 32'h40000000, 1'b0, 1'b0, 3);
      pin(28'h0000008, 8'd127, 1'b0, 32'h34000000, 1'b0, 1'b0, 26);
      pin(28'h4000004, 8'd127, 1'b0, 32'h3F800000, 1'b0, 1'b0, 3);
      pin(28'h400000C, 8'd127, 1'b0, 32'h3F800002, 1'b0, 1'b0, 3);
      pin(28'h7FFFFFC, 8'd254, 1'b0, 32'h7F800000, 1'b1, 1'b0, 3);
      pin(28'h0000000, 8'd5,   1'b1, 32'h80000000, 1'b0, 1'b1, 1);
    end
    if (in_reset) begin
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_result", result_o, 32'h0);
      chk("rst_flags", {30'h0, overflow_o, zero_o}, 32'h0);
      n_done = n_sent;
      prev_ov = 1'b0;
    end else begin
      chk("in_ready", 32'(in_ready), 32'(n_sent == n_done));
      if (out_valid) begin
        if (n_sent == n_done) begin
          chk("stray_out_valid", 32'(out_valid), 32'd0);
        end else begin
          e = arr[n_done % 1024];
          chk("result", result_o, e.res);
          chk("overflow", 32'(overflow_o), 32'(e.ovf));
          chk("zero", 32'(zero_o), 32'(e.zero));
          if (!prev_ov) chk("latency", 32'(int'(($time - e.acc - 5) / 10)), 32'(e.lat));
          if (out_ready) n_done++;
        end
      end
      prev_ov = out_valid;
    end
  end

  // Downstream backpressure.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      out_ready = hold ? 1'b0 : ($urandom_range(0, 9) < 7);
    end
  end

  task automatic send(input logic [27:0] s, input logic [7:0] e, input logic sg);
    int n;
    exp_t r;
    n = 0;
    while (!in_ready && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      $display("FAIL in_ready_timeout: got in_ready=0 want 1 within 500 cycles");
      $fatal(1, "in_ready timeout");
    end
    sum_i = s;
    exp_i = e;
    sign_i = sg;
    in_valid = 1'b1;
    @(posedge clk);
    r = model(s, e, sg);
    r.acc = $time;
    arr[n_sent % 1024] = r;
    n_sent++;
    n_vec++;
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (n_done != n_sent && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n_done != n_sent) begin
      $display("FAIL drain_timeout: got %0d outputs want %0d", n_done, n_sent);
      $fatal(1, "drain timeout");
    end
  endtask

  initial begin
    logic [27:0] one, s;
    logic [7:0]  e;
    int pos, sel;
    one = 28'd1;
    in_valid = 1'b0;
    sum_i = '0;
    exp_i = '0;
    sign_i = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    in_reset = 1'b0;
    @(posedge clk);
    #1;

    // Directed vectors
    send(28'h4000000, 8'd127, 1'b0);
    send(28'h8000000, 8'd127, 1'b0);
    send(28'h0000008, 8'd127, 1'b0);
    send(28'h4000004, 8'd127, 1'b0);
    send(28'h400000C, 8'd127, 1'b0);
    send(28'h7FFFFFC, 8'd254, 1'b0);
    send(28'h8000000, 8'd254, 1'b1);
    send(28'h0000001, 8'd1,   1'b0);
    send(28'h0000008, 8'd1,   1'b1);
    send(28'h3FFFFFC, 8'd2,   1'b0);
    drain();

    // Random vectors
    for (int i = 0; i < 300; i++) begin
      sel = $urandom_range(0, 99);
      if (sel < 8) begin
        s = '0;
      end else begin
        pos = $urandom_range(0, 27);
        s = (28'($urandom) & ((one << pos) - one)) | (one << pos);
      end
      sel = $urandom_range(0, 99);
      if (sel < 25)      e = 8'($urandom_range(1, 8));
      else if (sel < 35) e = 8'($urandom_range(250, 254));
      else               e = 8'($urandom_range(1, 254));
      send(s, e, 1'($urandom));
    end
    drain();

    // Zero sum under held backpressure: outputs must stay put
    hold = 1'b1;
    @(posedge clk);
    #1;
    send(28'h0, 8'd100, 1'b1);
    repeat (7) @(posedge clk);
    #1;
    hold = 1'b0;
    drain();

    // Reset in the middle of a long normalisation
    hold = 1'b1;
    send(28'h0000008, 8'd127, 1'b0);
    repeat (5) @(posedge clk);
    #3;
    in_reset = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    in_reset = 1'b0;
    hold = 1'b0;
    @(posedge clk);
    #1;
    send(28'h4000000, 8'd127, 1'b0);
    drain();
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
